daisy_tx: RTL and testbench
===========================

# daisy_tx

Serial transmitter for the daisy-chain (SATA) link, the outgoing counterpart to the ADC stream ingest. It consumes an AXI4-Stream of signed samples, frames each sample with a header and parity bit, and shifts it out one bit per clock on `daisy_p_o[0]`, MSB first. When no data is available it fills the line with idle/training words so the far-end receiver can keep word alignment. It sits between a stream source (acquisition path or ASG) and the `daisy_p_o`/`daisy_n_o` output buffers in `red_pitaya_top`, clocked by the fast serial clock.

## Interface

Parameters:
- `DW`, 16: sample (payload) width in bits.
- `IDLE`, 16'hA5C3: payload of idle/training words; width `DW`.
- `TRN`, 16: number of idle words sent after enable before any data is accepted; range 1..65535.

Ports:
- `clk`  in  1: serial clock; one line bit per cycle.
- `rst`  in  1: reset, asynchronous, active-high.
- `en`  in  1: link enable; level-sensitive and sampled only at word boundaries (see Operation).
- `s_tdata`  in  `DW`: sample, two's complement.
- `s_tlast`  in  1: marks the last sample of a frame; carried in the header.
- `s_tvalid`  in  1: AXI4-Stream valid.
- `s_tready`  out  1: AXI4-Stream ready.
- `ser_o`  out  1: serial line bit, registered.
- `busy_o`  out  1: high in every state except OFF.
- `tx_cnt_o`  out  32: count of accepted data words; wraps at 2^32.

## Operation

Word format, `W = DW+3` bits, sent MSB first:
- 2-bit header: `2'b10` = data, `2'b11` = data with last, `2'b01` = idle.
- `DW`-bit payload.
- 1 even-parity bit `p`, where `p = ^{hdr,payload}`.
- Header `2'b00` never appears on the line. The line holds 0 in OFF.

State machine:
- **OFF:** `ser_o`=0, `s_tready`=0. If `en`=1, load an idle word, clear the train counter, and go to TRAIN.
- **TRAIN:** send idle words back-to-back.
  - At each word boundary (last bit cycle), increment the train counter.
  - When the counter reaches `TRN`, go to RUN; that boundary is the first data-capable load.
- **RUN:** at every word boundary, `s_tready`=1 for exactly that cycle.
  - If `s_tvalid`=1, load a data word (header from `s_tlast`) and increment `tx_cnt_o`.
  - Otherwise, load an idle word.
- **Disable:** `en` is examined only at word boundaries in TRAIN/RUN.
  - If `en`=0, the current word finishes, `s_tready` stays 0 at that boundary, and the state goes to OFF.
  - In that case `ser_o` is 0 from the following cycle.

Handshake and datapath rules:
- `s_tready` is a registered-state decode; it never depends on `s_tvalid`.
- The source may hold `s_tvalid` for any duration. Data is never dropped or duplicated.
- A bit counter runs 0..W-1 and wraps; the boundary is `bit_cnt == W-1`.
- The shift register is `W` bits and shifts left; `ser_o` is its MSB.

Reset:
- Asynchronous reset forces OFF with `ser_o`=0, `s_tready`=0, `busy_o`=0, `tx_cnt_o`=0, and all counters cleared.
- Reset in mid-word aborts the word. No partial-word recovery is required.

## Timing

- Word period: `W` cycles (19 for `DW`=16). Maximum throughput is one sample per `W` cycles.
- Handshake at cycle t: the header MSB appears on `ser_o` at t+1 and the parity bit at t+W.
- Enable latency: `en` high in OFF at cycle t → first idle header bit at t+1.
- First `s_tready` is at t+`TRN`·W.
- `tx_cnt_o` updates at t+1 after a handshake.
- `busy_o` rises at t+1 after the OFF exit and falls at the cycle `ser_o` goes to 0.

## Structure

- Package `daisy_pkg` holds:
  - header localparams (`HDR_DATA`, `HDR_LAST`, `HDR_IDLE`);
  - the state enum (`OFF`, `TRAIN`, `RUN`);
  - a function `daisy_word(hdr, payload)` returning the `W`-bit word with parity.
- The shared package lets the future `daisy_rx` reuse these definitions.
- Single module, no sub-module. The FSM, bit counter, train counter, shift register and `tx_cnt` all fit comfortably in one block.

## Test plan

With `DW`=16, `IDLE`=16'hA5C3, `TRN`=4:
1. **Training:** reset, then `en`=1 with `s_tvalid`=0.
   - `ser_o` repeats the 19-bit idle word `01_A5C3_p` (p = even parity over `2'b01` and 16'hA5C3).
   - First `s_tready` pulse at cycle 4·19 after the OFF exit; `busy_o`=1.
2. **Single sample:** in RUN, hold `s_tvalid`=1, `s_tdata`=16'h8001, `s_tlast`=1 until ready.
   - Exactly one handshake.
   - Next word is `11_8001_p` (p = even parity over `2'b11` and 16'h8001).
   - Following word is idle; `tx_cnt_o`=1.
3. **Back-to-back:** stream 16'h0000, 16'hFFFF, 16'h1234 continuously.
   - Words appear contiguously with no idle words between them.
   - One `s_tready` pulse per 19 cycles; `tx_cnt_o`=3.
4. **Disable mid-word:** drop `en` at bit 7 of a data word.
   - The word completes all 19 bits.
   - No `s_tready` at that boundary; `ser_o`=0 and `busy_o`=0 afterwards.
5. **Reset mid-word:** assert `rst` at bit 10 of a data word.
   - `ser_o`, `s_tready`, `busy_o` and `tx_cnt_o` go to 0 immediately.
   - Re-enabling repeats full training (4 idle words).
6. **Parity/header check:** the bench receiver decodes 1000 random samples with random `s_tlast` and random `s_tvalid` gaps.
   - No parity errors, no `2'b00` headers, data and last flags match in order.

Source files
------------

// File: rtl/daisy_pkg.sv
// Shared definitions for the daisy-chain serial link (transmitter and future receiver).
package daisy_pkg;

    localparam logic [1:0] HDR_DATA = 2'b10;
    localparam logic [1:0] HDR_LAST = 2'b11;
    localparam logic [1:0] HDR_IDLE = 2'b01;

    typedef enum logic [1:0] {
        OFF,
        TRAIN,
        RUN
    } state_t;

    // Builds {hdr, payload, p} right-aligned in 64 bits; payload must fit in dw bits
    // (dw <= 60). p makes the whole word even parity; callers truncate to dw+3 bits.
    function automatic logic [63:0] daisy_word(input logic [1:0] hdr,
                                               input logic [63:0] payload,
                                               input int dw);
        logic [63:0] body;
        body = ({62'd0, hdr} << dw) | payload;
        return {body[62:0], ^body};
    endfunction

endpackage

// File: rtl/daisy_tx.sv
// Daisy-chain serial transmitter: frames AXI4-Stream samples into header/payload/parity
// words and shifts them out MSB first, filling gaps with idle words.
module daisy_tx
    import daisy_pkg::*;
#(
    parameter int            DW   = 16,
    parameter logic [DW-1:0] IDLE = 16'hA5C3,
    parameter int            TRN  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] s_tdata,
    input  logic          s_tlast,
    input  logic          s_tvalid,
    output logic          s_tready,
    output logic          ser_o,
    output logic          busy_o,
    output logic [31:0]   tx_cnt_o
);

    localparam int W  = DW + 3;
    localparam int BW = $clog2(W);

    state_t          state, state_nxt;
    logic [BW-1:0]   bit_cnt;
    logic [15:0]     trn_cnt;
    logic [W-1:0]    shreg;
    logic [31:0]     tx_cnt;
    logic            boundary;
    logic            last_trn;
    logic [W-1:0]    idle_word;
    logic [W-1:0]    data_word;

    assign boundary  = (bit_cnt == BW'(W - 1));
    assign last_trn  = (trn_cnt == 16'(TRN - 1));
    assign idle_word = W'(daisy_word(HDR_IDLE, 64'(IDLE), DW));
    assign data_word = W'(daisy_word(s_tlast ? HDR_LAST : HDR_DATA, 64'(s_tdata), DW));

    assign ser_o    = shreg[W-1];
    assign busy_o   = (state != OFF);
    assign tx_cnt_o = tx_cnt;

    // Next state and ready: ready only at a word boundary that can carry data, never from valid.
    always_comb begin
        state_nxt = state;
        s_tready  = 1'b0;
        case (state)
            OFF: begin
                if (en) state_nxt = TRAIN;
            end
            TRAIN: begin
                if (boundary) begin
                    if (!en) begin
                        state_nxt = OFF;
                    end else if (last_trn) begin
                        state_nxt = RUN;
                        s_tready  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (boundary) begin
                    if (!en) state_nxt = OFF;
                    else     s_tready  = 1'b1;
                end
            end
            default: state_nxt = OFF;
        endcase
    end

    // State register plus shifter, bit/train counters and accepted-word counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= OFF;
            bit_cnt <= '0;
            trn_cnt <= '0;
            shreg   <= '0;
            tx_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (state == OFF) begin
                if (en) begin
                    shreg   <= idle_word;
                    bit_cnt <= '0;
                    trn_cnt <= '0;
                end
            end else if (!boundary) begin
                shreg   <= shreg << 1;
                bit_cnt <= bit_cnt + 1'b1;
            end else begin
                bit_cnt <= '0;
                if (state_nxt == OFF) begin
                    // Line drops to 0 right after the final bit of the last word.
                    shreg <= '0;
                end else begin
                    if (state == TRAIN) trn_cnt <= trn_cnt + 1'b1;
                    if (s_tready && s_tvalid) begin
                        shreg  <= data_word;
                        tx_cnt <= tx_cnt + 1'b1;
                    end else begin
                        shreg <= idle_word;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_daisy_tx.sv
// Self-checking bench for daisy_tx: cycle model of the line plus a serial receiver/scoreboard.
module tb_daisy_tx;

    localparam int          DW   = 16;
    localparam int          TRN  = 4;
    localparam int          W    = DW + 3;
    localparam logic [15:0] IDLE = 16'hA5C3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [15:0] s_tdata = '0;
    logic        s_tlast = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        ser_o;
    logic        busy_o;
    logic [31:0] tx_cnt_o;

    int vecs = 0;
    int errs = 0;

    typedef struct {
        logic        last;
        logic [15:0] d;
    } item_t;
    item_t sq[$];

    always #5 clk = ~clk;

    daisy_tx #(.DW(DW), .IDLE(IDLE), .TRN(TRN)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .s_tdata  (s_tdata),
        .s_tlast  (s_tlast),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .ser_o    (ser_o),
        .busy_o   (busy_o),
        .tx_cnt_o (tx_cnt_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic [1:0] h, input logic [DW-1:0] d);
        logic [W-2:0] b;
        b = {h, d};
        return {b, 1'($countones(b) % 2)};
    endfunction

    // Reference model: time since enable, current word, accepted count.
    bit           m_on = 1'b0;
    int           m_n = 0;
    logic [W-1:0] m_word = '0;
    logic [31:0]  m_cnt = '0;

    function automatic logic m_ready();
        return m_on && (m_n % W == W - 1) && en && (m_n / W + 1 >= TRN);
    endfunction

    initial begin : model
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_on = 1'b0; m_n = 0; m_cnt = '0;
            end else if (!m_on) begin
                if (en) begin
                    m_on = 1'b1; m_n = 0; m_word = mk(2'b01, IDLE);
                end
            end else if (m_n % W != W - 1) begin
                m_n++;
            end else if (!en) begin
                m_on = 1'b0;
            end else begin
                if (m_ready() && s_tvalid) begin
                    m_word = mk(s_tlast ? 2'b11 : 2'b10, s_tdata);
                    m_cnt++;
                end else begin
                    m_word = mk(2'b01, IDLE);
                end
                m_n++;
            end
        end
    end

    // Serial receiver: words are aligned to the rise of busy_o.
    logic [W-1:0] rx_sh = '0;
    int rx_n = 0;
    int rx_data = 0;
    int rx_idle = 0;

    task automatic decode(input logic [W-1:0] w);
        item_t it;
        chk("rx_parity", 64'($countones(w) % 2), 0);
        chk("rx_hdr_nz", 64'(w[W-1:W-2] == 2'b00), 0);
        if (w[W-1:W-2] == 2'b01) begin
            rx_idle++;
            chk("rx_idle_pl", 64'(w[W-3:1]), 64'(IDLE));
        end else if (w[W-1]) begin
            rx_data++;
            if (sq.size() == 0) begin
                chk("rx_unexpected", 1, 0);
            end else begin
                it = sq.pop_front();
                chk("rx_data", 64'(w[W-3:1]), 64'(it.d));
                chk("rx_last", 64'(w[W-2]), 64'(it.last));
            end
        end
    endtask

    initial begin : mon
        forever begin
            @(negedge clk);
            chk("ser", 64'(ser_o), 64'(m_on ? m_word[W-1-(m_n % W)] : 1'b0));
            chk("ready", 64'(s_tready), 64'(m_ready()));
            chk("busy", 64'(busy_o), 64'(m_on));
            chk("tx_cnt", 64'(tx_cnt_o), 64'(m_cnt));
            if (!busy_o) begin
                rx_n = 0;
            end else begin
                rx_sh = {rx_sh[W-2:0], ser_o};
                rx_n++;
                if (rx_n == W) begin
                    rx_n = 0;
                    decode(rx_sh);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds valid until the DUT takes the sample; returns handshake time.
    task automatic send(input logic [15:0] d, input logic l, output time hs_t);
        int  n;
        bit  hs;
        item_t it;
        s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
        hs = 1'b0; n = 0; hs_t = 0;
        while (!hs && n < 400) begin
            @(negedge clk);
            hs = s_tready;
            if (hs) hs_t = $time;
            @(posedge clk);
            #1;
            n++;
        end
        s_tvalid = 1'b0;
        if (hs) begin
            it.d = d; it.last = l;
            sq.push_back(it);
        end else begin
            chk("hs_timeout", 1, 0);
        end
    endtask

    // Counts negedges from now until the first ready pulse (bounded).
    task automatic wait_ready(output int n);
        n = 0;
        while (n < 500) begin
            @(negedge clk);
            n++;
            if (s_tready) break;
        end
    endtask

    initial begin : watchdog
        #900000;
        chk("watchdog", 1, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin : main
        time t0, t1, t2, t3;
        int  n, rx0;

        // Reset state
        tick(3);
        chk("rst_ser", 64'(ser_o), 0);
        chk("rst_ready", 64'(s_tready), 0);
        chk("rst_busy", 64'(busy_o), 0);
        chk("rst_cnt", 64'(tx_cnt_o), 0);
        rst = 1'b0;
        tick(2);

        // Training
        en = 1'b1;
        wait_ready(n);
        chk("trn_latency", 64'(n), 64'(1 + TRN * W));
        chk("trn_busy", 64'(busy_o), 1);
        tick(1);
        chk("trn_idle_words", 64'(rx_idle), 64'(TRN));

        // Single sample with last
        send(16'h8001, 1'b1, t0);
        tick(2 * W);
        chk("single_cnt", 64'(tx_cnt_o), 1);
        chk("single_rx", 64'(rx_data), 1);

        // Back-to-back
        send(16'h0000, 1'b0, t1);
        send(16'hFFFF, 1'b0, t2);
        send(16'h1234, 1'b0, t3);
        chk("b2b_gap1", 64'((t2 - t1) / 10), 64'(W));
        chk("b2b_gap2", 64'((t3 - t2) / 10), 64'(W));
        tick(2 * W);
        chk("b2b_cnt", 64'(tx_cnt_o), 4);
        chk("b2b_rx", 64'(rx_data), 4);

        // Disable at bit 7 of a data word
        send(16'h5A5A, 1'b0, t0);
        tick(7);
        en = 1'b0;
        n = 0;
        repeat (3 * W) begin
            @(negedge clk);
            if (s_tready) n++;
        end
        chk("dis_ready", 64'(n), 0);
        chk("dis_busy", 64'(busy_o), 0);
        chk("dis_ser", 64'(ser_o), 0);
        chk("dis_words", 64'(rx_data), 5);

        // Reset at bit 10 of a data word
        tick(1);
        en = 1'b1;
        wait_ready(n);
        tick(1);
        send(16'h1357, 1'b1, t0);
        tick(10);
        rst = 1'b1;
        #1;
        chk("rstm_ser", 64'(ser_o), 0);
        chk("rstm_ready", 64'(s_tready), 0);
        chk("rstm_busy", 64'(busy_o), 0);
        chk("rstm_cnt", 64'(tx_cnt_o), 0);
        tick(2);
        sq.delete();
        rst = 1'b0;
        wait_ready(n);
        chk("retrn_latency", 64'(n), 64'(1 + TRN * W));
        tick(1);

        // Random stream with gaps and random last flags
        rx0 = rx_data;
        for (int i = 0; i < 1000; i++) begin
            tick($urandom_range(0, 20));
            send(16'($urandom), 1'($urandom_range(0, 1)), t0);
        end
        tick(3 * W);
        chk("rand_drained", 64'(sq.size()), 0);
        chk("rand_cnt", 64'(tx_cnt_o), 1000);
        chk("rand_rx", 64'(rx_data - rx0), 1000);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
